// File: rtl/f3m_pkg.sv
// Shared constants, trit codes and per-trit GF(3) arithmetic for the GF(3^97) datapath.
// Trits are packed two bits each, {hi,lo}: 00=0, 01=1, 10=2.
package f3m_pkg;

  localparam int M     = 97;
  localparam int WIDTH = 2 * M - 1;
  localparam int TAP   = 12;

  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] ONE  = 2'b01;
  localparam logic [1:0] TWO  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] trit_neg(input logic [1:0] t);
    return {t[0], t[1]};
  endfunction

  // Mod-3 add/sub cell; the 2-bit code equals the trit value, so plain add-and-fold works.
  function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/f3m_mult_serial_if.sv
// Operand/result bundle of the serial GF(3^97) multiplier with its start/done handshake.
interface f3m_mult_serial_if;

  logic                    start;
  logic [f3m_pkg::WIDTH:0] A;
  logic [f3m_pkg::WIDTH:0] B;
  logic [f3m_pkg::WIDTH:0] C;
  logic                    busy;
  logic                    done;

  modport master (output start, output A, output B, input C, input busy, input done);
  modport slave  (input start, input A, input B, output C, output busy, output done);

endinterface

// File: rtl/f3m_mult_step.sv
// One MSB-first multiply step: acc' = (acc * x mod P) + b * A, with P = x^97 + x^12 + 2.
module f3m_mult_step
  import f3m_pkg::*;
(
  input  logic [WIDTH:0] acc_i,
  input  logic [WIDTH:0] a_i,
  input  logic [1:0]     b_i,
  output logic [WIDTH:0] acc_o
);

  logic [WIDTH:0] shift_s;
  logic [WIDTH:0] ba_s;
  logic [1:0]     t_s;

  // x^97 = -x^12 - 2 = 2x^12 + 1, so the trit shifted out feeds back into trit 0 and (negated) trit TAP.
  always_comb begin
    t_s                  = acc_i[WIDTH -: 2];
    shift_s              = {acc_i[WIDTH-2:0], ZERO};
    shift_s[1:0]         = t_s;
    shift_s[2*TAP +: 2]  = trit_add(acc_i[2*TAP-2 +: 2], trit_neg(t_s));
  end

  // Scalar multiple of the multiplicand selected by the current trit of B.
  always_comb begin
    ba_s = '0;
    case (b_i)
      ZERO: ba_s = '0;
      ONE:  ba_s = a_i;
      TWO: begin
        for (int i = 0; i < M; i++) begin
          ba_s[2*i +: 2] = trit_neg(a_i[2*i +: 2]);
        end
      end
      default: ba_s = '0;
    endcase
  end

  // Carry-free trit-wise sum of the reduced shift and the scaled multiplicand.
  always_comb begin
    acc_o = '0;
    for (int i = 0; i < M; i++) begin
      acc_o[2*i +: 2] = trit_add(shift_s[2*i +: 2], ba_s[2*i +: 2]);
    end
  end

endmodule

// File: rtl/f3m_mult_serial.sv
// Digit-serial GF(3^97) multiplier: consumes one trit of B per cycle, MSB first,
// producing C = A*B mod (x^97 + x^12 + 2) M cycles after an accepted start.
module f3m_mult_serial
  import f3m_pkg::*;
#(
  parameter int ITER_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  f3m_mult_serial_if.slave    bus
);

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]      a_q, a_d;
  logic [WIDTH:0]      b_q, b_d;
  logic [WIDTH:0]      acc_q, acc_d;
  logic [WIDTH:0]      c_q, c_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          b_trit_s;
  logic [WIDTH:0]      step_acc_s;

  assign b_trit_s = b_q[{cnt_q, 1'b0} +: 2];

  f3m_mult_step u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_trit_s),
    .acc_o (step_acc_s)
  );

  // Handshake FSM: latch operands on start, step until the last trit, then publish C.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          acc_d   = '0;
          cnt_d   = ITER_W'(M - 1);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        acc_d = step_acc_s;
        if (cnt_q == {ITER_W{1'b0}}) begin
          c_d     = step_acc_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q - {{(ITER_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.C    = c_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_f3m_mult_serial.sv
// Scoreboard bench for f3m_mult_serial: a cycle model tracks busy/done, a polynomial
// reference model supplies expected products, directed cases use hand-derived constants.
module tb_f3m_mult_serial;
  import f3m_pkg::*;

  typedef logic [WIDTH:0] elem_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  f3m_mult_serial_if bus();

  f3m_mult_serial #(.ITER_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input elem_t got, input elem_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic elem_t rand_elem();
    elem_t r;
    for (int i = 0; i < M; i++) begin
      r[2*i +: 2] = 2'($urandom_range(0, 2));
    end
    return r;
  endfunction

  // Schoolbook product then reduce top-down using x^97 = 2x^12 + 1 (mod 3).
  function automatic elem_t ref_mult(input elem_t a, input elem_t b);
    int    p[0:2*M-2];
    int    ta, tb, c;
    elem_t r;
    for (int i = 0; i < 2*M-1; i++) p[i] = 0;
    for (int i = 0; i < M; i++) begin
      ta = int'(a[2*i +: 2]);
      for (int j = 0; j < M; j++) begin
        tb = int'(b[2*j +: 2]);
        p[i+j] = p[i+j] + ta * tb;
      end
    end
    for (int d = 2*M-2; d >= M; d--) begin
      c = p[d] % 3;
      p[d] = 0;
      p[d-M+TAP] = p[d-M+TAP] + 2 * c;
      p[d-M]     = p[d-M] + c;
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  elem_t sb[$];
  logic  mon_en    = 1'b0;
  logic  mdl_busy  = 1'b0;
  logic  mdl_done  = 1'b0;
  logic  rst_seen  = 1'b0;
  int    mdl_cnt   = 0;
  elem_t last_c    = '0;

  // Cycle model: accepts start only when idle, completes M edges later.
  always @(posedge clk) begin
    if (reset) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
      rst_seen <= 1'b1;
      sb.delete();
    end else begin
      rst_seen <= 1'b0;
      mdl_done <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          mdl_busy <= 1'b0;
          mdl_done <= 1'b1;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (bus.start) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= M - 1;
        sb.push_back(ref_mult(bus.A, bus.B));
      end
    end
  end

  // Monitor on the falling edge: flags, scoreboard pop on done, C hold otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) last_c = '0;
      check_eq("busy", elem_t'(bus.busy), elem_t'(mdl_busy));
      check_eq("done", elem_t'(bus.done), elem_t'(mdl_done));
      if (bus.done) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", elem_t'(sb.size()), elem_t'(1));
        end else begin
          last_c = sb.pop_front();
          check_eq("sb_c", bus.C, last_c);
        end
      end else begin
        check_eq("c_hold", bus.C, last_c);
      end
    end
  end

  task automatic run_op(input elem_t a, input elem_t b, output elem_t c_out, output int lat);
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.A = rand_elem(); bus.B = rand_elem();
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 50);
    end
    bus.start = 1'b0;
    c_out = bus.C;
    @(negedge clk);
    check_eq("pulse_1cyc", elem_t'(bus.done), elem_t'(0));
    check_eq("post_hold", bus.C, c_out);
  endtask

  initial begin
    elem_t a_v, b_v, c_v, one_v;
    int    lat;
    one_v = elem_t'(1);
    reset = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check_eq("rst_busy", elem_t'(bus.busy), elem_t'(0));
    check_eq("rst_done", elem_t'(bus.done), elem_t'(0));
    check_eq("rst_c", bus.C, elem_t'(0));
    reset = 1'b0;

    run_op(one_v, one_v, c_v, lat);
    check_eq("id_c", c_v, elem_t'(1));
    check_eq("id_lat", elem_t'(lat), elem_t'(M));

    run_op(elem_t'(4), one_v << (2*(M-1)), c_v, lat);
    check_eq("red_c", c_v, (one_v << 25) | one_v);
    check_eq("red_lat", elem_t'(lat), elem_t'(M));

    run_op(elem_t'(2053), elem_t'(2), c_v, lat);
    check_eq("neg_c", c_v, elem_t'(1034));

    run_op(elem_t'(0), rand_elem(), c_v, lat);
    check_eq("zero_c", c_v, elem_t'(0));

    a_v = rand_elem(); b_v = rand_elem();
    run_op(a_v, b_v, c_v, lat);
    check_eq("rnd_c", c_v, ref_mult(a_v, b_v));

    // Abort in the 40th RUN cycle.
    @(negedge clk);
    bus.A = rand_elem(); bus.B = rand_elem(); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", elem_t'(bus.busy), elem_t'(0));
    check_eq("abort_done", elem_t'(bus.done), elem_t'(0));
    check_eq("abort_c", bus.C, elem_t'(0));

    a_v = rand_elem(); b_v = rand_elem();
    run_op(a_v, b_v, c_v, lat);
    check_eq("post_abort_c", c_v, ref_mult(a_v, b_v));
    check_eq("post_abort_lat", elem_t'(lat), elem_t'(M));

    // Start held high with operands changing every cycle: back-to-back on each done.
    for (int i = 0; i < 400 * (M + 1); i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.A = rand_elem(); bus.B = rand_elem();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (M + 10) @(negedge clk);
    check_eq("sb_drain", elem_t'(sb.size()), elem_t'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
